// File: rtl/bj_hand_ctrl.sv
// bj_hand_ctrl: sequencer that deals cards into the 4-slot blackjack hand register and decides bust/21/stand.
// Optional build macro SOFT_ACE_EN: count one ace as 11 when that does not bust the hand.
module bj_hand_ctrl #(
    parameter int BUST_LIMIT = 21,
    parameter int INIT_CARDS = 2
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       DEAL,
    input  logic       HIT,
    input  logic       STAND,
    input  logic       CARD_VLD,
    input  logic [3:0] CARD,
    input  logic [4:0] CNT,
    output logic       CARD_REQ,
    output logic       REG_LD,
    output logic       REG_CLR,
    output logic [3:0] REG_D,
    output logic [1:0] REG_POS,
    output logic [2:0] NCARDS,
    output logic [4:0] TOTAL,
    output logic       BUSY,
    output logic       BUST,
    output logic       HIT21,
    output logic       DONE
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_REQ, ST_LOAD, ST_SETTLE, ST_EVAL, ST_WAIT, ST_DONE
    } state_t;

    localparam logic [5:0] LIM  = 6'(BUST_LIMIT);
    localparam logic [2:0] INIT = 3'(INIT_CARDS);

    state_t     state, nxt;
    logic [3:0] card_q;
    logic [2:0] ncards;
    logic [4:0] total, total_c;
    logic       bust, hit21, card_ok, over, at_lim;

    assign card_ok = CARD < 4'd13;

`ifdef SOFT_ACE_EN
    logic       ace;
    logic [5:0] soft;
    assign soft    = {1'b0, CNT} + 6'd10;
    assign total_c = (ace && soft <= LIM) ? soft[4:0] : CNT;
    // ace flag: cleared at the start of every hand, set when an ace is loaded
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) ace <= 1'b0;
        else if (state == ST_CLEAR) ace <= 1'b0;
        else if (state == ST_LOAD && card_q == 4'd1) ace <= 1'b1;
    end
`else
    assign total_c = CNT;
`endif

    assign over   = {1'b0, total_c} > LIM;
    assign at_lim = {1'b0, total_c} == LIM;

    // state register; async reset withdraws any pending card request at once
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) state <= ST_IDLE;
        else state <= nxt;
    end

    // hand bookkeeping: card latch, card count, registered total and flags
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            card_q <= '0;
            ncards <= '0;
            total  <= '0;
            bust   <= 1'b0;
            hit21  <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ncards <= '0;
                    bust   <= 1'b0;
                    hit21  <= 1'b0;
                end
                ST_REQ:  if (CARD_VLD && card_ok) card_q <= CARD;
                ST_LOAD: ncards <= ncards + 3'd1;
                ST_EVAL: begin
                    total <= total_c;
                    bust  <= over;
                    hit21 <= !over && at_lim;
                end
                default: ;
            endcase
        end
    end

    // next-state decision
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE: nxt = DEAL ? ST_CLEAR : state;
            ST_CLEAR:  nxt = ST_REQ;
            ST_REQ:    nxt = (CARD_VLD && card_ok) ? ST_LOAD : ST_REQ;
            ST_LOAD:   nxt = ST_SETTLE;
            ST_SETTLE: nxt = ST_EVAL;
            ST_EVAL:   nxt = (over || at_lim) ? ST_DONE :
                             (ncards < INIT)  ? ST_REQ  :
                             (ncards == 3'd4) ? ST_DONE : ST_WAIT;
            ST_WAIT:   nxt = STAND ? ST_DONE : HIT ? ST_REQ : ST_WAIT;
            default:   nxt = ST_IDLE;
        endcase
    end

    assign CARD_REQ = state == ST_REQ;
    assign REG_LD   = state == ST_LOAD;
    assign REG_CLR  = state == ST_CLEAR;
    assign REG_D    = card_q;
    assign REG_POS  = ncards[1:0];
    assign NCARDS   = ncards;
    assign TOTAL    = total;
    assign BUST     = bust;
    assign HIT21    = hit21;
    assign DONE     = state == ST_DONE;
    assign BUSY     = !(state == ST_IDLE || state == ST_WAIT || state == ST_DONE);
endmodule
